// File: rtl/timer_defs.sv
// Shared timer definitions: state encoding, field limits and preset clamp helper.
// Used by the countdown timer, the stopwatch and the watch top level.
package timer_defs;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [14:0] MSEC_MAX = 15'd999;
    localparam logic [6:0]  SEC_MAX  = 7'd59;
    localparam logic [6:0]  MIN_MAX  = 7'd63;

    function automatic logic [6:0] clamp7(input logic [6:0] v, input logic [6:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Command and display bundle of the countdown timer.
// The controller (watch top level or bench) is the master; the timer is the slave.
interface countdown_timer_if;
    import timer_defs::*;

    logic        clear;
    logic        load;
    logic [6:0]  load_min;
    logic [6:0]  load_sec;
    logic        start;
    logic        pause;
    logic        ack;
    logic [6:0]  min;
    logic [6:0]  sec;
    logic [14:0] msec;
    logic        running;
    logic        done;
    logic        alarm;

    modport master (
        output clear, load, load_min, load_sec, start, pause, ack,
        input  min, sec, msec, running, done, alarm
    );

    modport slave (
        input  clear, load, load_min, load_sec, start, pause, ack,
        output min, sec, msec, running, done, alarm
    );

endinterface

// File: rtl/countdown_timer_ms_prescaler.sv
// Millisecond prescaler: counts clk cycles while enabled and emits a one-cycle tick
// every CLK_PER_MS enabled cycles. restart zeroes the count; the count holds while en is low.
module ms_prescaler #(
    parameter int CLK_PER_MS = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_PER_MS - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: loads min:sec, counts min:sec:msec down once per millisecond tick,
// pulses done and sets a sticky alarm on reaching 00:00.000.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | stopped; fields hold the loaded preset (or zero)
//  RUN     | counting down on every prescaler tick
//  PAUSED  | frozen mid-count; prescaler phase kept for a seamless resume
//  EXPIRED | reached 00:00.000; alarm held until ack, clear or load
module countdown_timer
    import timer_defs::*;
#(
    parameter int CLK_PER_MS = 1
) (
    input  logic               clk,
    input  logic               rst,
    countdown_timer_if.slave   bus
);

    state_t      state, state_nxt;
    logic [6:0]  min_q, min_nxt;
    logic [6:0]  sec_q, sec_nxt;
    logic [14:0] msec_q, msec_nxt;
    logic        alarm_q, alarm_nxt;
    logic        done_q, done_nxt;
    logic        running_q;
    logic        tick;
    logic        presc_restart;
    logic        time_zero;
    logic        expiring;

    ms_prescaler #(.CLK_PER_MS(CLK_PER_MS)) u_presc (
        .clk     (clk),
        .rst     (rst),
        .en      (state == RUN),
        .restart (presc_restart),
        .tick    (tick)
    );

    assign time_zero = (min_q == 7'd0) && (sec_q == 7'd0) && (msec_q == 15'd0);
    assign expiring  = tick && (min_q == 7'd0) && (sec_q == 7'd0) && (msec_q <= 15'd1);

    always_comb begin
        state_nxt     = state;
        min_nxt       = min_q;
        sec_nxt       = sec_q;
        msec_nxt      = msec_q;
        alarm_nxt     = alarm_q;
        done_nxt      = 1'b0;
        presc_restart = 1'b0;

        if (bus.clear) begin
            min_nxt       = 7'd0;
            sec_nxt       = 7'd0;
            msec_nxt      = 15'd0;
            alarm_nxt     = 1'b0;
            presc_restart = 1'b1;
            state_nxt     = IDLE;
        end else if (bus.load && (state != RUN)) begin
            min_nxt       = clamp7(bus.load_min, MIN_MAX);
            sec_nxt       = clamp7(bus.load_sec, SEC_MAX);
            msec_nxt      = 15'd0;
            alarm_nxt     = 1'b0;
            presc_restart = 1'b1;
            state_nxt     = IDLE;
        end else begin
            // Borrow chain; an all-zero value holds rather than wrapping.
            if (tick) begin
                if (msec_q != 15'd0) begin
                    msec_nxt = msec_q - 15'd1;
                end else if (sec_q != 7'd0) begin
                    msec_nxt = MSEC_MAX;
                    sec_nxt  = sec_q - 7'd1;
                end else if (min_q != 7'd0) begin
                    msec_nxt = MSEC_MAX;
                    sec_nxt  = SEC_MAX;
                    min_nxt  = min_q - 7'd1;
                end
            end

            // Expiry outranks a pause raised on the same cycle.
            if (expiring) begin
                state_nxt = EXPIRED;
                done_nxt  = 1'b1;
                alarm_nxt = 1'b1;
            end else if (bus.pause && (state == RUN)) begin
                state_nxt = PAUSED;
            end else if (bus.start && ((state == IDLE) || (state == PAUSED)) && !time_zero) begin
                state_nxt     = RUN;
                presc_restart = (state == IDLE);
            end else if (bus.ack && (state == EXPIRED)) begin
                state_nxt = IDLE;
                alarm_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            min_q     <= 7'd0;
            sec_q     <= 7'd0;
            msec_q    <= 15'd0;
            alarm_q   <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            min_q     <= min_nxt;
            sec_q     <= sec_nxt;
            msec_q    <= msec_nxt;
            alarm_q   <= alarm_nxt;
            done_q    <= done_nxt;
            running_q <= (state_nxt == RUN);
        end
    end

    assign bus.min     = min_q;
    assign bus.sec     = sec_q;
    assign bus.msec    = msec_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (1 and 4 clocks per ms) driven in lockstep and
// compared every cycle against a remaining-milliseconds reference model, plus directed values.
module tb_countdown_timer;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear_s = 0, load_s = 0, start_s = 0, pause_s = 0, ack_s = 0;
    logic [6:0] load_min_s = 0, load_sec_s = 0;

    int errors = 0;
    int checks = 0;

    int per[2]     = '{1, 4};
    int m_st[2]    = '{0, 0};
    int m_rem[2]   = '{0, 0};
    int m_pc[2]    = '{0, 0};
    int m_done[2]  = '{0, 0};
    int m_alarm[2] = '{0, 0};

    countdown_timer_if i1 ();
    countdown_timer_if i4 ();

    assign i1.clear = clear_s;   assign i4.clear = clear_s;
    assign i1.load = load_s;     assign i4.load = load_s;
    assign i1.load_min = load_min_s; assign i4.load_min = load_min_s;
    assign i1.load_sec = load_sec_s; assign i4.load_sec = load_sec_s;
    assign i1.start = start_s;   assign i4.start = start_s;
    assign i1.pause = pause_s;   assign i4.pause = pause_s;
    assign i1.ack = ack_s;       assign i4.ack = ack_s;

    countdown_timer #(.CLK_PER_MS(1)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
    countdown_timer #(.CLK_PER_MS(4)) dut4 (.clk(clk), .rst(rst), .bus(i4.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = M_IDLE; m_rem[k] = 0; m_pc[k] = 0; m_done[k] = 0; m_alarm[k] = 0;
        end
    endtask

    // Reference: remaining time kept as a single millisecond count.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int  lm, ls;
            bit  tk, exp_now;
            tk = (m_st[k] == M_RUN) && (m_pc[k] == per[k] - 1);
            exp_now = 0;
            m_done[k] = 0;
            if (clear_s) begin
                m_rem[k] = 0; m_alarm[k] = 0; m_pc[k] = 0; m_st[k] = M_IDLE;
            end else if (load_s && m_st[k] != M_RUN) begin
                lm = (int'(load_min_s) > 63) ? 63 : int'(load_min_s);
                ls = (int'(load_sec_s) > 59) ? 59 : int'(load_sec_s);
                m_rem[k] = lm * 60000 + ls * 1000;
                m_alarm[k] = 0; m_pc[k] = 0; m_st[k] = M_IDLE;
            end else begin
                if (m_st[k] == M_RUN) m_pc[k] = tk ? 0 : m_pc[k] + 1;
                if (tk && m_rem[k] > 0) begin
                    m_rem[k] = m_rem[k] - 1;
                    exp_now = (m_rem[k] == 0);
                end
                if (exp_now) begin
                    m_st[k] = M_EXP; m_done[k] = 1; m_alarm[k] = 1;
                end else if (pause_s && m_st[k] == M_RUN) begin
                    m_st[k] = M_PAUSED;
                end else if (start_s && (m_st[k] == M_IDLE || m_st[k] == M_PAUSED) && m_rem[k] != 0) begin
                    if (m_st[k] == M_IDLE) m_pc[k] = 0;
                    m_st[k] = M_RUN;
                end else if (ack_s && m_st[k] == M_EXP) begin
                    m_st[k] = M_IDLE; m_alarm[k] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("n1.min", 32'(i1.min), m_rem[0] / 60000);
        chk("n1.sec", 32'(i1.sec), (m_rem[0] / 1000) % 60);
        chk("n1.msec", 32'(i1.msec), m_rem[0] % 1000);
        chk("n1.running", 32'(i1.running), 32'(m_st[0] == M_RUN));
        chk("n1.done", 32'(i1.done), m_done[0]);
        chk("n1.alarm", 32'(i1.alarm), m_alarm[0]);
        chk("n4.min", 32'(i4.min), m_rem[1] / 60000);
        chk("n4.sec", 32'(i4.sec), (m_rem[1] / 1000) % 60);
        chk("n4.msec", 32'(i4.msec), m_rem[1] % 1000);
        chk("n4.running", 32'(i4.running), 32'(m_st[1] == M_RUN));
        chk("n4.done", 32'(i4.done), m_done[1]);
        chk("n4.alarm", 32'(i4.alarm), m_alarm[1]);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input int mn, input int sc);
        load_min_s = 7'(mn); load_sec_s = 7'(sc); load_s = 1;
        cycle();
        load_s = 0;
    endtask

    task automatic do_start();
        start_s = 1; cycle(); start_s = 0;
    endtask

    task automatic do_pause();
        pause_s = 1; cycle(); pause_s = 0;
    endtask

    task automatic do_ack();
        ack_s = 1; cycle(); ack_s = 0;
    endtask

    task automatic do_clear();
        clear_s = 1; cycle(); clear_s = 0;
    endtask

    task automatic chk_time1(input string tag, input int mn, input int sc, input int ms);
        chk({tag, ".min"}, 32'(i1.min), mn);
        chk({tag, ".sec"}, 32'(i1.sec), sc);
        chk({tag, ".msec"}, 32'(i1.msec), ms);
    endtask

    initial begin
        int r;
        model_reset();
        #3;
        chk("rst.min", 32'(i1.min), 0);
        chk("rst.msec", 32'(i4.msec), 0);
        chk("rst.running", 32'(i1.running), 0);
        chk("rst.alarm", 32'(i4.alarm), 0);
        #9 rst = 0;
        cycles(2);

        // 0:02 countdown to expiry
        do_load(0, 2);
        chk_time1("load02", 0, 2, 0);
        do_start();
        chk("start.running", 32'(i1.running), 1);
        cycle();
        chk_time1("first_tick", 0, 1, 999);
        cycles(1998);
        chk_time1("pre_expiry", 0, 0, 1);
        chk("pre_expiry.done", 32'(i1.done), 0);
        cycle();
        chk_time1("expiry", 0, 0, 0);
        chk("expiry.done", 32'(i1.done), 1);
        chk("expiry.alarm", 32'(i1.alarm), 1);
        chk("expiry.running", 32'(i1.running), 0);
        cycle();
        chk("post_expiry.done", 32'(i1.done), 0);
        chk("post_expiry.alarm", 32'(i1.alarm), 1);
        cycles(6100);
        chk("n4_expired.alarm", 32'(i4.alarm), 1);

        // EXPIRED ignores start; ack clears alarm
        do_start();
        chk("exp_start.running", 32'(i1.running), 0);
        chk("exp_start.alarm", 32'(i1.alarm), 1);
        do_ack();
        chk("ack.alarm", 32'(i1.alarm), 0);
        chk("ack.alarm4", 32'(i4.alarm), 0);

        // minute borrow
        do_load(1, 0);
        do_start();
        cycle();
        chk_time1("borrow", 0, 59, 999);
        do_pause();
        do_clear();

        // clamp, zero-start rejection
        do_load(70, 75);
        chk_time1("clamp", 63, 59, 0);
        do_load(0, 0);
        do_start();
        cycles(3);
        chk("zero_start.running", 32'(i1.running), 0);
        chk("zero_start.done", 32'(i1.done), 0);

        // pause/resume, prescaler phase kept
        do_load(0, 2);
        do_start();
        cycles(4);
        do_pause();
        cycles(100);
        chk_time1("paused", 0, 1, 995);
        chk("paused.n4msec", 32'(i4.msec), 999);
        chk("paused.running", 32'(i1.running), 0);
        do_start();
        cycles(10);
        chk("resume.n4msec_pre", 32'(i4.msec), 997);
        cycle();
        chk("resume.n4msec", 32'(i4.msec), 996);
        chk_time1("resume", 0, 1, 984);

        // clear+load+start same cycle
        clear_s = 1; load_s = 1; start_s = 1; load_min_s = 7'd5; load_sec_s = 7'd5;
        cycle();
        clear_s = 0; load_s = 0; start_s = 0;
        chk_time1("cls", 0, 0, 0);
        chk("cls.running", 32'(i1.running), 0);

        // randomized command mix
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 999));
            clear_s = (r < 5);
            load_s  = (r >= 5 && r < 25);
            start_s = (r >= 25 && r < 80);
            pause_s = (r >= 80 && r < 100);
            ack_s   = (r >= 100 && r < 120);
            if ($urandom_range(0, 3) == 0) begin
                load_min_s = 7'($urandom_range(0, 127));
                load_sec_s = 7'($urandom_range(0, 127));
            end else begin
                load_min_s = 7'd0;
                load_sec_s = 7'($urandom_range(0, 1));
            end
            cycle();
        end
        clear_s = 0; load_s = 0; start_s = 0; pause_s = 0; ack_s = 0;

        // async reset mid-run
        do_load(0, 3);
        do_start();
        cycles(7);
        #3 rst = 1;
        #1;
        model_reset();
        chk_time1("async_rst", 0, 0, 0);
        chk("async_rst.running", 32'(i1.running), 0);
        chk("async_rst.n4msec", 32'(i4.msec), 0);
        #2 rst = 0;
        cycle();
        do_load(0, 1);
        do_start();
        cycle();
        chk_time1("after_rst", 0, 0, 999);
        cycles(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
